// File: rtl/systolic_host_link_if.sv
// Host-side bundle of the systolic tile link: parallel TX frames in,
// reassembled RX frames out, each with a valid/ready handshake.
interface systolic_host_link_if;
  logic [15:0] tx_col_data;
  logic [3:0]  tx_col_ctrl;
  logic [15:0] tx_row_data;
  logic [3:0]  tx_row_ctrl;
  logic        tx_valid;
  logic        tx_ready;

  logic [15:0] rx_col_data;
  logic [15:0] rx_row_data;
  logic [3:0]  rx_col_ctrl;
  logic [3:0]  rx_row_ctrl;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_overflow;

  // Host / test controller side.
  modport master (
    output tx_col_data, tx_col_ctrl, tx_row_data, tx_row_ctrl, tx_valid,
    input  tx_ready,
    input  rx_col_data, rx_row_data, rx_col_ctrl, rx_row_ctrl, rx_valid,
    input  rx_overflow,
    output rx_ready
  );

  // Link endpoint side.
  modport slave (
    input  tx_col_data, tx_col_ctrl, tx_row_data, tx_row_ctrl, tx_valid,
    output tx_ready,
    output rx_col_data, rx_row_data, rx_col_ctrl, rx_row_ctrl, rx_valid,
    output rx_overflow,
    input  rx_ready
  );
endinterface

// File: rtl/systolic_host_link.sv
// Host endpoint of the nibble-serial systolic tile link. Serialises 40-bit
// frames (col16, row16, cctl4, rctl4) MSB nibble first over 4 cycles and
// reassembles the returning stream. The frame counter is phase-locked to
// the tile through the shared synchronous reset.
module systolic_host_link (
  input  logic                clk,
  input  logic                rst_n,
  systolic_host_link_if.slave host,
  output logic [7:0]          tile_ui_out,
  output logic [1:0]          tile_ctrl_out,
  input  logic [7:0]          tile_uo_in,
  input  logic [1:0]          tile_ctrl_in,
  output logic [1:0]          frame_phase
);

  logic [1:0]  phase;
  logic        last_phase;

  // TX state
  logic        pend_full;
  logic [15:0] pend_col;
  logic [15:0] pend_row;
  logic [3:0]  pend_cctl;
  logic [3:0]  pend_rctl;
  logic [15:0] col_sr;
  logic [15:0] row_sr;
  logic [3:0]  cctl_sr;
  logic [3:0]  rctl_sr;
  logic        tx_ready_int;
  logic        tx_accept;

  // RX state
  logic [11:0] col_rsr;
  logic [11:0] row_rsr;
  logic [2:0]  cctl_rsr;
  logic [2:0]  rctl_rsr;
  logic [39:0] rx_frame;
  logic        frame_live;
  logic        rx_room;
  logic [39:0] rx_hold;
  logic        rx_valid_q;
  logic        rx_overflow_q;

  assign last_phase  = (phase == 2'd3);
  assign frame_phase = phase;

  // Pending can always be accepted at phase 3 because it drains that same edge.
  assign tx_ready_int  = !pend_full || last_phase;
  assign tx_accept     = host.tx_valid && tx_ready_int;
  assign host.tx_ready = tx_ready_int;

  // Line outputs come straight from the shift-register MSBs, so they are flop outputs.
  assign tile_ui_out   = {col_sr[15:12], row_sr[15:12]};
  assign tile_ctrl_out = {cctl_sr[3], rctl_sr[3]};

  // Last nibble/bit of the frame is taken live at phase 3, not via the shift register.
  assign rx_frame   = {col_rsr, tile_uo_in[7:4], row_rsr, tile_uo_in[3:0],
                       cctl_rsr, tile_ctrl_in[1], rctl_rsr, tile_ctrl_in[0]};
  assign frame_live = last_phase && (rx_frame != '0);
  assign rx_room    = !rx_valid_q || host.rx_ready;

  assign host.rx_col_data = rx_hold[39:24];
  assign host.rx_row_data = rx_hold[23:8];
  assign host.rx_col_ctrl = rx_hold[7:4];
  assign host.rx_row_ctrl = rx_hold[3:0];
  assign host.rx_valid    = rx_valid_q;
  assign host.rx_overflow = rx_overflow_q;

  // Free-running frame counter, wraps 3 -> 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
    end else begin
      phase <= phase + 2'd1;
    end
  end

  // TX: shift out between frame boundaries, reload at phase 3 (pending, direct, or idle).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_col  <= '0;
      pend_row  <= '0;
      pend_cctl <= '0;
      pend_rctl <= '0;
      col_sr    <= '0;
      row_sr    <= '0;
      cctl_sr   <= '0;
      rctl_sr   <= '0;
    end else if (last_phase) begin
      if (pend_full) begin
        col_sr    <= pend_col;
        row_sr    <= pend_row;
        cctl_sr   <= pend_cctl;
        rctl_sr   <= pend_rctl;
        // A handshake in the draining cycle refills pending.
        pend_full <= tx_accept;
        if (tx_accept) begin
          pend_col  <= host.tx_col_data;
          pend_row  <= host.tx_row_data;
          pend_cctl <= host.tx_col_ctrl;
          pend_rctl <= host.tx_row_ctrl;
        end
      end else if (host.tx_valid) begin
        col_sr  <= host.tx_col_data;
        row_sr  <= host.tx_row_data;
        cctl_sr <= host.tx_col_ctrl;
        rctl_sr <= host.tx_row_ctrl;
      end else begin
        col_sr  <= '0;
        row_sr  <= '0;
        cctl_sr <= '0;
        rctl_sr <= '0;
      end
    end else begin
      col_sr  <= {col_sr[11:0], 4'h0};
      row_sr  <= {row_sr[11:0], 4'h0};
      cctl_sr <= {cctl_sr[2:0], 1'b0};
      rctl_sr <= {rctl_sr[2:0], 1'b0};
      if (tx_accept) begin
        pend_full <= 1'b1;
        pend_col  <= host.tx_col_data;
        pend_row  <= host.tx_row_data;
        pend_cctl <= host.tx_col_ctrl;
        pend_rctl <= host.tx_row_ctrl;
      end
    end
  end

  // RX: collect the first three nibbles/bits of each frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_rsr  <= '0;
      row_rsr  <= '0;
      cctl_rsr <= '0;
      rctl_rsr <= '0;
    end else if (!last_phase) begin
      col_rsr  <= {col_rsr[7:0], tile_uo_in[7:4]};
      row_rsr  <= {row_rsr[7:0], tile_uo_in[3:0]};
      cctl_rsr <= {cctl_rsr[1:0], tile_ctrl_in[1]};
      rctl_rsr <= {rctl_rsr[1:0], tile_ctrl_in[0]};
    end
  end

  // RX: hold non-idle frames for the host; drop and flag when the holder is busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_hold       <= '0;
      rx_valid_q    <= 1'b0;
      rx_overflow_q <= 1'b0;
    end else begin
      if (rx_valid_q && host.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (frame_live) begin
        if (rx_room) begin
          rx_hold    <= rx_frame;
          rx_valid_q <= 1'b1;
        end else begin
          rx_overflow_q <= 1'b1;
        end
      end
    end
  end

endmodule
